// File: rtl/key_entry_pkg.sv
// key_entry_pkg: shared types and constants for the keypad entry/display block.
package key_entry_pkg;
    typedef enum logic [1:0] {IDLE, QUAL, HELD, REL} state_t;
    localparam logic [3:0] DIG_SEL_N0   = 4'b1110;
    localparam logic [3:0] DIG_SEL_N1   = 4'b1101;
    localparam logic [3:0] DIG_SEL_N2   = 4'b1011;
    localparam logic [3:0] DIG_SEL_N3   = 4'b0111;
    localparam logic [3:0] BCD_BLANK    = 4'hF;
    localparam logic [3:0] MAX_KEY_CODE = 4'd9;

    function automatic logic [3:0] dig_sel_pat(input logic [1:0] sel);
        return sel == 2'd0 ? DIG_SEL_N0 :
               sel == 2'd1 ? DIG_SEL_N1 :
               sel == 2'd2 ? DIG_SEL_N2 : DIG_SEL_N3;
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: press/release qualification FSM; emits one accept per debounced press.
module key_debounce
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_hit,
    input  logic [3:0] i_key_code,
    output logic       o_accept,
    output logic [3:0] o_cand,
    output logic       o_strobe,
    output logic [3:0] o_key_last
);
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    state_t      r_state, w_state_nx;
    logic [15:0] r_cnt, w_cnt_nx;
    logic [3:0]  r_cand, w_cand_nx;
    logic        r_strobe, w_accept;
    logic [3:0]  r_key_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cand     <= '0;
            r_strobe   <= 1'b0;
            r_key_last <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_cand   <= w_cand_nx;
            r_strobe <= w_accept;
            if (w_accept) r_key_last <= r_cand;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: if (i_key_hit) begin
                w_state_nx = QUAL;
                w_cand_nx  = i_key_code;
                w_cnt_nx   = 16'd1;
            end
            QUAL: if (!i_key_hit) begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end else if (i_key_code != r_cand) begin
                w_cand_nx = i_key_code;
                w_cnt_nx  = 16'd1;
            end else if (r_cand <= MAX_KEY_CODE) begin
                // Out-of-range codes park here with the count frozen, so they never accept.
                if (r_cnt == CNT_LAST) begin
                    w_state_nx = HELD;
                    w_cnt_nx   = '0;
                    w_accept   = 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 16'd1;
                end
            end
            HELD: if (!i_key_hit) begin
                w_state_nx = REL;
                w_cnt_nx   = 16'd1;
            end
            REL: if (i_key_hit) begin
                w_state_nx = HELD;
                w_cnt_nx   = '0;
            end else if (r_cnt == CNT_LAST) begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end else begin
                w_cnt_nx = r_cnt + 16'd1;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign o_accept   = w_accept;
    assign o_cand     = r_cand;
    assign o_strobe   = r_strobe;
    assign o_key_last = r_key_last;
endmodule

// File: rtl/key_entry_display.sv
// key_entry_display: debounced key entry into a 4-digit shift register, multiplexed onto a 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits above d0.
module key_entry_display
    import key_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int SCAN_DIV_BITS   = 15
) (
    input  logic       f4m,
    input  logic       rst_n,
    input  logic       key_hit,
    input  logic [3:0] key_code,
    input  logic       clear,
    output logic [3:0] dig_sel_n,
    output logic [3:0] bcd,
    output logic       key_strobe,
    output logic [3:0] key_last
);
    localparam int SW = SCAN_DIV_BITS + 2;

    logic          w_accept;
    logic [3:0]    w_cand;
    logic [15:0]   r_digits, w_digits_nx;
    logic [SW-1:0] r_scan, w_scan_nx;
    logic [1:0]    w_sel;
    logic [3:0]    w_digit, w_bcd_nx;
    logic [3:0]    r_dig_sel_n, r_bcd;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .i_clk      (f4m),
        .i_rst_n    (rst_n),
        .i_key_hit  (key_hit),
        .i_key_code (key_code),
        .o_accept   (w_accept),
        .o_cand     (w_cand),
        .o_strobe   (key_strobe),
        .o_key_last (key_last)
    );

    // Display registers are fed from next-state values so an accept or clear shows on its own edge.
    assign w_digits_nx = w_accept ? {(clear ? 12'h000 : r_digits[11:0]), w_cand}
                                  : (clear ? 16'h0000 : r_digits);
    assign w_scan_nx   = r_scan + 1'b1;
    assign w_sel       = w_scan_nx[SW-1 -: 2];
    assign w_digit     = w_digits_nx[{w_sel, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic w_blank;
    assign w_blank  = (w_sel != 2'd0) && ((w_digits_nx >> {w_sel, 2'b00}) == 16'h0000);
    assign w_bcd_nx = w_blank ? BCD_BLANK : w_digit;
`else
    assign w_bcd_nx = w_digit;
`endif

    always_ff @(posedge f4m or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_scan      <= '0;
            r_dig_sel_n <= DIG_SEL_N0;
            r_bcd       <= '0;
        end else begin
            r_digits    <= w_digits_nx;
            r_scan      <= w_scan_nx;
            r_dig_sel_n <= dig_sel_pat(w_sel);
            r_bcd       <= w_bcd_nx;
        end
    end

    assign dig_sel_n = r_dig_sel_n;
    assign bcd       = r_bcd;
endmodule

// File: tb/tb_key_entry_display.sv
// tb_key_entry_display: directed self-checking bench for key_entry_display (DEBOUNCE_CYCLES=8, SCAN_DIV_BITS=2).
module tb_key_entry_display;
    logic       f4m = 1'b0;
    logic       rst_n, key_hit, clear;
    logic [3:0] key_code, dig_sel_n, bcd, key_last, v;
    logic       key_strobe;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         strobe_cnt = 0;
    int         s0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    key_entry_display #(.DEBOUNCE_CYCLES(8), .SCAN_DIV_BITS(2)) dut (
        .f4m        (f4m),
        .rst_n      (rst_n),
        .key_hit    (key_hit),
        .key_code   (key_code),
        .clear      (clear),
        .dig_sel_n  (dig_sel_n),
        .bcd        (bcd),
        .key_strobe (key_strobe),
        .key_last   (key_last)
    );

    always #5 f4m = ~f4m;

    always @(negedge f4m) if (key_strobe) strobe_cnt++;

    task automatic step();
        @(posedge f4m);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_digit(input int s, output logic [3:0] val);
        logic [3:0] pat;
        bit         ok;
        pat = ~(4'b0001 << s);
        ok  = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (dig_sel_n === pat) ok = 1'b1;
            else step();
        end
        n_tests++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL sel_timeout: observed %b expected %b", dig_sel_n, pat);
        end
        val = bcd;
    endtask

    task automatic press(input logic [3:0] c);
        key_code = c;
        key_hit  = 1'b1;
        repeat (8) step();
        key_hit = 1'b0;
        repeat (10) step();
    endtask

    initial begin
        rst_n = 1'b0; key_hit = 1'b0; key_code = 4'd0; clear = 1'b0;
        // 1. reset values and scan cadence
        repeat (3) @(posedge f4m);
        #1;
        check("rst_sel", 32'(dig_sel_n), 32'b1110);
        check("rst_bcd", 32'(bcd), 0);
        check("rst_strobe", 32'(key_strobe), 0);
        check("rst_last", 32'(key_last), 0);
        rst_n = 1'b1;
        repeat (3) step();
        check("scan_3", 32'(dig_sel_n), 32'b1110);
        step();
        check("scan_4", 32'(dig_sel_n), 32'b1101);
        repeat (4) step();
        check("scan_8", 32'(dig_sel_n), 32'b1011);
        repeat (4) step();
        check("scan_12", 32'(dig_sel_n), 32'b0111);
        // 2. clean press of 5, strobe on 8th edge
        key_code = 4'd5; key_hit = 1'b1;
        repeat (7) step();
        check("p5_pre", 32'(key_strobe), 0);
        step();
        check("p5_strobe", 32'(key_strobe), 1);
        check("p5_last", 32'(key_last), 5);
        repeat (12) step();
        check("p5_once", 32'(strobe_cnt), 1);
        key_hit = 1'b0;
        repeat (10) step();
        read_digit(0, v); check("p5_d0", 32'(v), 5);
        read_digit(1, v); check("p5_d1", 32'(v), 32'(LZ));
        // 3. bounce then press 3, then release dropout
        key_code = 4'd3;
        for (int i = 0; i < 5; i++) begin
            key_hit = (i % 2 == 1);
            step();
        end
        s0 = strobe_cnt;
        key_hit = 1'b1;
        repeat (7) step();
        check("p3_pre", 32'(key_strobe), 0);
        step();
        check("p3_strobe", 32'(key_strobe), 1);
        step();
        check("p3_cnt", 32'(strobe_cnt), 32'(s0 + 1));
        key_hit = 1'b0;
        repeat (5) step();
        key_hit = 1'b1;
        repeat (5) step();
        check("dropout", 32'(strobe_cnt), 32'(s0 + 1));
        key_hit = 1'b0;
        repeat (10) step();
        read_digit(0, v); check("p3_d0", 32'(v), 3);
        read_digit(1, v); check("p3_d1", 32'(v), 5);
        // 4. shift and overflow
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd9);
        check("sh_last", 32'(key_last), 9);
        read_digit(3, v); check("sh_d3", 32'(v), 2);
        read_digit(0, v); check("sh_d0", 32'(v), 9);
        read_digit(1, v); check("sh_d1", 32'(v), 4);
        read_digit(2, v); check("sh_d2", 32'(v), 3);
        // 5. clear on the accept edge, then rejected code 12
        key_code = 4'd6; key_hit = 1'b1;
        repeat (7) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("cl_strobe", 32'(key_strobe), 1);
        key_hit = 1'b0;
        repeat (10) step();
        read_digit(0, v); check("cl_d0", 32'(v), 6);
        read_digit(1, v); check("cl_d1", 32'(v), 32'(LZ));
        read_digit(2, v); check("cl_d2", 32'(v), 32'(LZ));
        read_digit(3, v); check("cl_d3", 32'(v), 32'(LZ));
        s0 = strobe_cnt;
        key_code = 4'd12; key_hit = 1'b1;
        repeat (30) step();
        check("rej_cnt", 32'(strobe_cnt), 32'(s0));
        check("rej_last", 32'(key_last), 6);
        key_hit = 1'b0;
        repeat (10) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        read_digit(0, v); check("clr_d0", 32'(v), 0);
        check("clr_last", 32'(key_last), 6);
        // 6. reset while qualifying, key still held
        key_code = 4'd7; key_hit = 1'b1;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_last", 32'(key_last), 0);
        check("mid_rst_sel", 32'(dig_sel_n), 32'b1110);
        step();
        rst_n = 1'b1;
        repeat (7) step();
        check("rq_pre", 32'(key_strobe), 0);
        step();
        check("rq_strobe", 32'(key_strobe), 1);
        check("rq_last", 32'(key_last), 7);
        key_hit = 1'b0;
        repeat (10) step();
        read_digit(0, v); check("rq_d0", 32'(v), 7);
        read_digit(1, v); check("rq_d1", 32'(v), 32'(LZ));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
